// File: rtl/output_menu_ctrl.sv
// output_menu_ctrl: button front end for the 8-way 24-bit display selector.
// Two-flop synchronizer and per-bit debounce on the raw buttons, a hold-to-repeat
// step FSM, a wrapping 3-bit selection, and a registered copy of the selected source.
// Optional feature macro: AUTO_SCAN_EN (idle auto-scan up-steps while auto_scan is high).
// Reset rst is synchronous and active-low.
module output_menu_ctrl #(
  parameter int DB_CYCLES    = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 8,
  parameter int SCAN_CYCLES  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   btn_raw,
  input  logic         auto_scan,
  input  logic [191:0] in_flat,
  output logic [2:0]   sel,
  output logic [23:0]  out,
  output logic         changed
);

  localparam int DBW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNTW = $clog2(RMAX + 1);
  localparam logic [DBW-1:0]  DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [CNTW-1:0] RD_LAST = CNTW'(REPEAT_DELAY - 1);
  localparam logic [CNTW-1:0] RR_LAST = CNTW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BOTH} state_t;

  logic [1:0]      sync1_reg, sync2_reg;
  logic [1:0]      db;
  state_t          state_reg;
  logic [CNTW-1:0] cnt_reg;
  logic            step_up_reg, step_dn_reg;
  logic [2:0]      sel_reg, sel_d_reg;
  logic [23:0]     out_reg;
  logic            changed_reg;
  logic [23:0]     src [8];

  // Unpack the flattened sources into an indexable array
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_src
      assign src[gi] = in_flat[24*gi +: 24];
    end
  endgenerate

  // Two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg <= 2'b00;
      sync2_reg <= 2'b00;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-bit debounce: level changes only after DB_CYCLES consecutive differing samples
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      logic [DBW-1:0] db_cnt_reg;
      logic           db_bit_reg;
      always_ff @(posedge clk) begin
        if (!rst) begin
          db_cnt_reg <= '0;
          db_bit_reg <= 1'b0;
        end else if (sync2_reg[gi] == db_bit_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
          db_bit_reg <= sync2_reg[gi];
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end
      assign db[gi] = db_bit_reg;
    end
  endgenerate

`ifdef AUTO_SCAN_EN
  localparam int SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYCLES - 1);
  logic [SCW-1:0] scan_cnt_reg;
`else
  logic unused_auto_scan;
  assign unused_auto_scan = auto_scan;
`endif

  // Step FSM: first step on press, hold delay, then periodic repeat; both buttons lock out stepping
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      step_up_reg <= 1'b0;
      step_dn_reg <= 1'b0;
`ifdef AUTO_SCAN_EN
      scan_cnt_reg <= '0;
`endif
    end else begin
      step_up_reg <= 1'b0;
      step_dn_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (db == 2'b01 || db == 2'b10) begin
            step_up_reg <= db[1];
            step_dn_reg <= db[0];
            cnt_reg     <= '0;
            state_reg   <= HOLD;
          end else if (db == 2'b11) begin
            state_reg <= BOTH;
          end
        end
        HOLD, REPEAT: begin
          if (db == 2'b00) begin
            state_reg <= IDLE;
          end else if (db == 2'b11) begin
            state_reg <= BOTH;
          end else if (cnt_reg == ((state_reg == HOLD) ? RD_LAST : RR_LAST)) begin
            step_up_reg <= db[1];
            step_dn_reg <= db[0];
            cnt_reg     <= '0;
            state_reg   <= REPEAT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          if (db == 2'b00) state_reg <= IDLE;
        end
      endcase
`ifdef AUTO_SCAN_EN
      // Scan only runs in IDLE with no buttons, so it never collides with a button step;
      // the db check keeps the button path the winner even so.
      if (state_reg == IDLE && db == 2'b00 && auto_scan) begin
        if (scan_cnt_reg == SCAN_LAST) begin
          scan_cnt_reg <= '0;
          step_up_reg  <= 1'b1;
        end else begin
          scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
      end else begin
        scan_cnt_reg <= '0;
      end
`endif
    end
  end

  // Wrapping selection register driven by the single-cycle step strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_reg <= 3'd0;
    end else if (step_up_reg) begin
      sel_reg <= sel_reg + 3'd1;
    end else if (step_dn_reg) begin
      sel_reg <= sel_reg - 3'd1;
    end
  end

  // Registered output mux and change strobe aligned with the first new output value
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_reg     <= 24'd0;
      sel_d_reg   <= 3'd0;
      changed_reg <= 1'b0;
    end else begin
      out_reg     <= src[sel_reg];
      sel_d_reg   <= sel_reg;
      changed_reg <= (sel_reg != sel_d_reg);
    end
  end

  assign sel     = sel_reg;
  assign out     = out_reg;
  assign changed = changed_reg;

endmodule
